// File: rtl/rst_seq_ctrl.sv
// Reset/run sequencer: releases NUM_CH reset domains in order behind ready handshakes, then times a run window.
// Optional RST_SEQ_REVERSE_EN: fault entry and soft restart re-assert released channels highest-first.
module rst_seq_ctrl #(
    parameter int NUM_CH        = 3,
    parameter int HOLD_CYCLES   = 4,
    parameter int STAGGER       = 2,
    parameter int READY_TIMEOUT = 8,
    parameter int RUN_CYCLES    = 10,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              run_done,
    output logic              fault,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [2:0]        state_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             gap;   // waiting out STAGGER before releasing channel idx+1

`ifdef RST_SEQ_REVERSE_EN
    logic unwinding;

    // Released channels always form a contiguous prefix, so the top set bit is the last one released.
    function automatic logic [NUM_CH-1:0] drop_top(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] r;
        logic              hit;
        r   = v;
        hit = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!hit && r[i]) begin
                r[i] = 1'b0;
                hit  = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    assign state_o = state;

    // NOTE: every register here is updated with <= so all branches see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            gap         <= 1'b0;
            ch_rst_n    <= '0;
            run_done    <= 1'b0;
            fault       <= 1'b0;
            cycle_count <= '0;
`ifdef RST_SEQ_REVERSE_EN
            unwinding   <= 1'b0;
`endif
        end else if (sw_rst_req) begin
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            gap         <= 1'b0;
            run_done    <= 1'b0;
            fault       <= 1'b0;
            cycle_count <= '0;
`ifdef RST_SEQ_REVERSE_EN
            ch_rst_n    <= drop_top(ch_rst_n);
            unwinding   <= |ch_rst_n;
        end else if (unwinding) begin
            // HOLD proper starts the cycle after channel 0 has gone back into reset.
            if (ch_rst_n == '0) begin
                state     <= S_HOLD;
                unwinding <= 1'b0;
                cnt       <= '0;
            end else begin
                ch_rst_n  <= drop_top(ch_rst_n);
            end
`else
            ch_rst_n    <= '0;
`endif
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        ch_rst_n[0] <= 1'b1;
                        state       <= S_RELEASE;
                        idx         <= '0;
                        gap         <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RELEASE: begin
                    if (gap) begin
                        if (cnt == STAG_LAST) begin
                            ch_rst_n[idx + IDX_W'(1)] <= 1'b1;
                            idx <= idx + IDX_W'(1);
                            gap <= 1'b0;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (ch_ready[idx]) begin
                        if (idx == LAST_IDX) begin
                            state       <= S_RUN;
                            cycle_count <= '0;
                            cnt         <= '0;
                        end else if (STAGGER == 0) begin
                            ch_rst_n[idx + IDX_W'(1)] <= 1'b1;
                            idx <= idx + IDX_W'(1);
                            cnt <= '0;
                        end else begin
                            gap <= 1'b1;
                            cnt <= '0;
                        end
                    end else if (cnt == TO_LAST) begin
                        state       <= S_FAULT;
                        fault       <= 1'b1;
                        cycle_count <= '0;
`ifdef RST_SEQ_REVERSE_EN
                        ch_rst_n    <= drop_top(ch_rst_n);
                        unwinding   <= 1'b1;
`else
                        ch_rst_n    <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (cycle_count == RUN_LAST) begin
                        state    <= S_DONE;
                        run_done <= 1'b1;
                    end
                    cycle_count <= cycle_count + CNT_W'(1);
                end

                S_DONE: begin
                    ch_rst_n <= '1;
                end

                default: begin
                    cycle_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default instance plus a STAGGER=0 instance with ready tied high.
// Expected cycle numbers are hand-derived; cycle 0 is the first cycle after reset drops.
module tb_rst_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sw_rst_req = 1'b0;
    logic        stuck1 = 1'b0;
    logic [2:0]  ch_ready;
    logic [2:0]  ch_rst_n;
    logic        run_done;
    logic        fault;
    logic [15:0] cycle_count;
    logic [2:0]  state_o;

    logic [2:0]  s0_rst_n;
    logic        s0_done;
    logic        s0_fault;
    logic [15:0] s0_count;
    logic [2:0]  s0_state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Each domain reports ready as soon as it is released, unless channel 1 is forced dead.
    assign ch_ready = stuck1 ? (ch_rst_n & 3'b101) : ch_rst_n;

    rst_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sw_rst_req  (sw_rst_req),
        .ch_ready    (ch_ready),
        .ch_rst_n    (ch_rst_n),
        .run_done    (run_done),
        .fault       (fault),
        .cycle_count (cycle_count),
        .state_o     (state_o)
    );

    rst_seq_ctrl #(.STAGGER(0)) dut_s0 (
        .clk         (clk),
        .reset       (reset),
        .sw_rst_req  (1'b0),
        .ch_ready    (3'b111),
        .ch_rst_n    (s0_rst_n),
        .run_done    (s0_done),
        .fault       (s0_fault),
        .cycle_count (s0_count),
        .state_o     (s0_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) advance();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // Scenario 1: clean sequence to DONE.
        advance();
        do_reset();
        check("rst_state", state_o, 0);
        check("rst_ch", ch_rst_n, 3'b000);
        check("rst_done", run_done, 0);
        check("rst_fault", fault, 0);
        check("rst_count", cycle_count, 0);
        goto(3);  check("hold_end_ch", ch_rst_n, 3'b000);
        goto(4);  check("ch0_rise", ch_rst_n, 3'b001);
                  check("release_state", state_o, 1);
        goto(6);  check("stagger_gap", ch_rst_n, 3'b001);
        goto(7);  check("ch1_rise", ch_rst_n, 3'b011);
        goto(9);  check("stagger_gap2", ch_rst_n, 3'b011);
        goto(10); check("ch2_rise", ch_rst_n, 3'b111);
        goto(11); check("run_state", state_o, 2);
                  check("run_count0", cycle_count, 0);
        goto(20); check("run_count9", cycle_count, 9);
                  check("run_not_done", run_done, 0);
        goto(21); check("done_flag", run_done, 1);
                  check("done_count", cycle_count, 10);
                  check("done_state", state_o, 3);
                  check("done_ch", ch_rst_n, 3'b111);
        goto(25); check("done_hold_count", cycle_count, 10);
                  check("done_hold_flag", run_done, 1);

        // Scenario 3: soft restart mid-run.
        do_reset();
        goto(15); check("pre_sw_count", cycle_count, 4);
        sw_rst_req = 1'b1;
        advance();
        sw_rst_req = 1'b0;
        check("sw_state", state_o, 0);
        check("sw_count", cycle_count, 0);
`ifdef RST_SEQ_REVERSE_EN
        check("sw_unwind2", ch_rst_n, 3'b011);
        goto(17); check("sw_unwind1", ch_rst_n, 3'b001);
        goto(18); check("sw_unwind0", ch_rst_n, 3'b000);
        goto(22); check("sw_rehold", ch_rst_n, 3'b000);
        goto(23); check("sw_rerelease", ch_rst_n, 3'b001);
`else
        check("sw_ch", ch_rst_n, 3'b000);
        goto(19); check("sw_rehold", ch_rst_n, 3'b000);
        goto(20); check("sw_rerelease", ch_rst_n, 3'b001);
`endif

        // Scenario 2: channel 1 never becomes ready.
        stuck1 = 1'b1;
        do_reset();
        goto(7);  check("stuck_ch1_rise", ch_rst_n, 3'b011);
        goto(14); check("stuck_pre_state", state_o, 1);
                  check("stuck_pre_fault", fault, 0);
        goto(15); check("fault_flag", fault, 1);
                  check("fault_state", state_o, 4);
`ifdef RST_SEQ_REVERSE_EN
                  check("fault_unwind1", ch_rst_n, 3'b001);
        goto(16); check("fault_unwind0", ch_rst_n, 3'b000);
                  check("fault_unwind_state", state_o, 4);
        goto(17); check("fault_to_hold", state_o, 0);
                  check("fault_sticky", fault, 1);
                  check("fault_no_done", run_done, 0);
`else
                  check("fault_ch", ch_rst_n, 3'b000);
        goto(20); check("fault_held_state", state_o, 4);
                  check("fault_sticky", fault, 1);
                  check("fault_no_done", run_done, 0);
                  check("fault_count", cycle_count, 0);
`endif
        stuck1 = 1'b0;

        // Scenario 4: reset pulse mid-RELEASE, then reset together with soft restart.
        do_reset();
        goto(8);  check("pre_rst_ch", ch_rst_n, 3'b011);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        check("midrst_state", state_o, 0);
        check("midrst_ch", ch_rst_n, 3'b000);
        check("midrst_count", cycle_count, 0);
        check("midrst_fault", fault, 0);
        goto(12); check("midrst_hold", ch_rst_n, 3'b000);
        goto(13); check("midrst_release", ch_rst_n, 3'b001);
        goto(14);
        reset = 1'b1;
        sw_rst_req = 1'b1;
        advance();
        reset = 1'b0;
        sw_rst_req = 1'b0;
        check("both_state", state_o, 0);
        check("both_ch", ch_rst_n, 3'b000);
        goto(18); check("both_hold", ch_rst_n, 3'b000);
        goto(19); check("both_release", ch_rst_n, 3'b001);

        // Scenario 5: zero stagger, ready tied high.
        do_reset();
        goto(3);  check("s0_hold", s0_rst_n, 3'b000);
        goto(4);  check("s0_ch0", s0_rst_n, 3'b001);
        goto(5);  check("s0_ch1", s0_rst_n, 3'b011);
        goto(6);  check("s0_ch2", s0_rst_n, 3'b111);
                  check("s0_not_run", s0_state, 1);
        goto(7);  check("s0_run", s0_state, 2);
                  check("s0_count0", s0_count, 0);
        goto(16); check("s0_not_done", s0_done, 0);
        goto(17); check("s0_done", s0_done, 1);
                  check("s0_done_count", s0_count, 10);
                  check("s0_no_fault", s0_fault, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
